// File: rtl/mantissa_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : mantissa_normalizer
//  Description : Converts a two's-complement adder result to sign-magnitude
//                and left-normalises it one bit per cycle with exponent fixup.
//  Revision    : 1.0  initial release
// ============================================================================
module mantissa_normalizer #(
    parameter int WIDTH = 23,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_sign1,
    input  logic             i_sign2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_carry,
    input  logic             i_shift_flag,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sign,
    output logic [WIDTH-1:0] o_mant,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_MANT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] C_EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] C_EXP_MAX  = {EXP_W{1'b1}};

    state_t             r_state, w_state_nxt;
    logic               r_sign, w_sign_nxt;
    logic [WIDTH-1:0]   r_mag, w_mag_nxt;
    logic [EXP_W-1:0]   r_exp, w_exp_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_overflow, w_overflow_nxt;
    logic               r_underflow, w_underflow_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_sign_nxt      = r_sign;
        w_mag_nxt       = r_mag;
        w_exp_nxt       = r_exp;
        w_zero_nxt      = r_zero;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = S_NORM;
                    w_zero_nxt      = 1'b0;
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                    w_exp_nxt       = i_exp;
                    w_sign_nxt      = i_sign1;
                    if (i_sign1 != i_sign2) begin
                        // Without a carry the difference went negative: negate it.
                        if (i_carry) begin
                            w_sign_nxt = 1'b0;
                            w_mag_nxt  = i_sum;
                        end else begin
                            w_sign_nxt = 1'b1;
                            w_mag_nxt  = ~i_sum + C_MANT_ONE;
                        end
                    end else if (i_shift_flag) begin
                        w_mag_nxt = {1'b1, i_sum[WIDTH-1:1]};
                        if (i_exp == C_EXP_MAX) begin
                            w_overflow_nxt = 1'b1;
                        end else begin
                            w_exp_nxt = i_exp + C_EXP_ONE;
                        end
                    end else begin
                        w_mag_nxt = i_sum;
                    end
                end
            end
            S_NORM: begin
                if (r_mag == '0) begin
                    w_zero_nxt  = 1'b1;
                    w_sign_nxt  = 1'b0;
                    w_exp_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else if (r_mag[WIDTH-1]) begin
                    w_state_nxt = S_DONE;
                end else if (r_exp == '0) begin
                    w_underflow_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_mag_nxt = {r_mag[WIDTH-2:0], 1'b0};
                    w_exp_nxt = r_exp - C_EXP_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sign      <= w_sign_nxt;
            r_mag       <= w_mag_nxt;
            r_exp       <= w_exp_nxt;
            r_zero      <= w_zero_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_sign      = r_sign;
    assign o_mant      = r_mag;
    assign o_exp       = r_exp;
    assign o_zero      = r_zero;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule
`default_nettype wire
